// File: rtl/latex_stream_receiver.sv
// latex_stream_receiver: captures one NUL-terminated line of packed-ASCII
// LaTeX characters, tracking length, XOR checksum and brace balance, and
// exposes the captured buffer through a registered read port.
module latex_stream_receiver #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    char_in,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   len,
  output logic [7:0]    csum,
  output logic          brace_err,
  output logic          overflow,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);
  localparam logic [7:0] CH_NUL    = 8'h00;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [3:0] DEPTH_MAX = 4'd15;

  state_e state_q, state_d;

  logic          start_q, start_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [3:0]    depth_q, depth_d;
  logic [7:0]    idle_q, idle_d;
  logic          brace_err_q, brace_err_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic [7:0]    mem_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic start_edge;
  logic arm;
  logic xfer;
  logic is_nul;
  logic idle_expire;

  assign start_edge  = start & ~start_q;
  assign arm         = start_edge & (state_q != CAPTURE);
  assign xfer        = char_valid & (state_q == CAPTURE);
  assign is_nul      = (char_in == CH_NUL);
  assign idle_expire = (state_q == CAPTURE) & ~xfer & ((idle_q + 8'd1) == TIMEOUT_L);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: arm from IDLE/DONE, finish on NUL or idle expiry.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if ((xfer && is_nul) || idle_expire) state_d = DONE;
      DONE:    if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake and status follow the registered state only.
  always_comb begin
    char_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      CAPTURE: begin
        char_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: clear on arm, update length/checksum/braces per
  // accepted character, run the idle timer on empty capture cycles.
  always_comb begin
    start_d     = start;
    len_d       = len_q;
    csum_d      = csum_q;
    depth_d     = depth_q;
    idle_d      = idle_q;
    brace_err_d = brace_err_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    wr_en       = 1'b0;
    wr_addr     = len_q[AW-1:0];
    wr_data     = char_in;
    rd_data_d   = mem_q[rd_addr];

    if (arm) begin
      len_d       = '0;
      csum_d      = '0;
      depth_d     = '0;
      idle_d      = '0;
      brace_err_d = 1'b0;
      overflow_d  = 1'b0;
      timeout_d   = 1'b0;
    end else if (state_q == CAPTURE) begin
      if (xfer) begin
        idle_d = '0;
        if (is_nul) begin
          if (depth_q != 4'd0) brace_err_d = 1'b1;
        end else begin
          csum_d = csum_q ^ char_in;
          // len_q[AW] set means the buffer already holds DEPTH characters.
          if (!len_q[AW]) begin
            wr_en = 1'b1;
            len_d = len_q + {{AW{1'b0}}, 1'b1};
          end else begin
            overflow_d = 1'b1;
          end
          if (char_in == CH_LBRACE) begin
            if (depth_q != DEPTH_MAX) depth_d = depth_q + 4'd1;
          end else if (char_in == CH_RBRACE) begin
            if (depth_q == 4'd0) brace_err_d = 1'b1;
            else                 depth_d     = depth_q - 4'd1;
          end
        end
      end else begin
        idle_d = idle_q + 8'd1;
        if (idle_expire) begin
          timeout_d = 1'b1;
          if (depth_q != 4'd0) brace_err_d = 1'b1;
        end
      end
    end
  end

  // Datapath and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      len_q       <= '0;
      csum_q      <= '0;
      depth_q     <= '0;
      idle_q      <= '0;
      brace_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      start_q     <= start_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      depth_q     <= depth_d;
      idle_q      <= idle_d;
      brace_err_q <= brace_err_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Character buffer write port; a same-cycle read sees the old contents.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately left out of reset so it maps onto
    // plain RAM; reads beyond len return whatever was last written.
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign len       = len_q;
  assign csum      = csum_q;
  assign brace_err = brace_err_q;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_latex_stream_receiver.sv
// tb_latex_stream_receiver: directed and randomized streams checked against
// a string-level reference model of the receiver.
module tb_latex_stream_receiver;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 255;

  typedef logic [7:0] byte_q_t [$];

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic [AW:0]   len;
  logic [7:0]    csum;
  logic          brace_err;
  logic          overflow;
  logic          timeout;

  int checks;
  int failures;

  // Reference model results.
  int         e_len;
  logic [7:0] e_csum;
  logic       e_berr;
  logic       e_ovf;
  logic       e_to;
  logic [7:0] exp_buf [DEPTH];

  latex_stream_receiver #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .len        (len),
    .csum       (csum),
    .brace_err  (brace_err),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    return q;
  endfunction

  // Reference model: walk the stream up to the first NUL using the
  // line-capture rules (store first DEPTH chars, XOR all, track braces).
  task automatic model_run(input byte_q_t s);
    int d;
    bit saw_nul;
    d       = 0;
    saw_nul = 1'b0;
    e_len   = 0;
    e_csum  = 8'h00;
    e_berr  = 1'b0;
    e_ovf   = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      if (!saw_nul) begin
        if (s[i] == 8'h00) begin
          saw_nul = 1'b1;
        end else begin
          e_csum = e_csum ^ s[i];
          if (e_len < DEPTH) begin
            exp_buf[e_len] = s[i];
            e_len++;
          end else begin
            e_ovf = 1'b1;
          end
          if (s[i] == 8'h7B) begin
            if (d < 15) d++;
          end else if (s[i] == 8'h7D) begin
            if (d == 0) e_berr = 1'b1;
            else        d--;
          end
        end
      end
    end
    if (d != 0) e_berr = 1'b1;
    e_to = ~saw_nul;
  endtask

  task automatic start_capture();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present each byte until accepted; with gaps, valid drops for one cycle
  // before every byte.
  task automatic send(input byte_q_t s, input bit gaps);
    int n;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps) begin
        char_valid = 1'b0;
        tick();
      end
      char_in    = s[i];
      char_valid = 1'b1;
      n = 0;
      while (!char_ready && n < 64) begin
        tick();
        n++;
      end
      check("send_ready", 32'(char_ready), 32'd1);
      tick();
    end
    char_valid = 1'b0;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_done"},  32'(done),      32'd1);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_ready"}, 32'(char_ready), 32'd0);
    check({tag, "_len"},   32'(len),       32'(e_len));
    check({tag, "_csum"},  32'(csum),      32'(e_csum));
    check({tag, "_berr"},  32'(brace_err), 32'(e_berr));
    check({tag, "_ovf"},   32'(overflow),  32'(e_ovf));
    check({tag, "_to"},    32'(timeout),   32'(e_to));
    for (int i = 0; i < e_len; i++) begin
      rd_addr = i[AW-1:0];
      tick();
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(exp_buf[i]));
    end
  endtask

  byte_q_t    q;
  int         n_chars;
  int         r;
  logic [7:0] c;
  bit         gap_mode;

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    rd_addr    = '0;

    // Reset state, observed while reset is held across clock edges.
    repeat (3) tick();
    check("rst_ready",   32'(char_ready), 32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_done",    32'(done),       32'd0);
    check("rst_len",     32'(len),        32'd0);
    check("rst_csum",    32'(csum),       32'd0);
    check("rst_rd_data", 32'(rd_data),    32'd0);
    check("rst_flags",   32'({brace_err, overflow, timeout}), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_ready", 32'(char_ready), 32'd0);

    // "e^{at}" with valid every cycle.
    start_capture();
    check("t1_ready_after_start", 32'(char_ready), 32'd1);
    check("t1_busy_after_start",  32'(busy),       32'd1);
    q = str2q("e^{at}");
    q.push_back(8'h00);
    send(q, 1'b0);
    model_run(q);
    check("t1_csum_const", 32'(csum), 32'(8'h65 ^ 8'h5E ^ 8'h7B ^ 8'h61 ^ 8'h74 ^ 8'h7D));
    check_results("t1");

    // Gapped stream with an unmatched closing brace.
    start_capture();
    q = str2q("\\frac{1}{s-a}}");
    q.push_back(8'h00);
    send(q, 1'b1);
    model_run(q);
    check("t2_len_const", 32'(len), 32'd14);
    check_results("t2");

    // "{{s": unbalanced at end; a start edge mid-capture must be ignored.
    start_capture();
    send(str2q("{{"), 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t3_busy_after_ignored_start", 32'(busy), 32'd1);
    q = str2q("s");
    q.push_back(8'h00);
    send(q, 1'b0);
    q = str2q("{{s");
    q.push_back(8'h00);
    model_run(q);
    check_results("t3");

    // DEPTH+3 characters: overflow, last three dropped but still XORed.
    start_capture();
    q = {};
    for (int i = 0; i < DEPTH + 3; i++) q.push_back(8'h78);
    q.push_back(8'h00);
    send(q, 1'b0);
    model_run(q);
    check("t4_csum_const", 32'(csum), 32'h78);
    check_results("t4");

    // Brace depth saturation: 16 opens then 15 closes balances.
    start_capture();
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'h7B);
    for (int i = 0; i < 15; i++) q.push_back(8'h7D);
    q.push_back(8'h00);
    send(q, 1'b0);
    model_run(q);
    check("t5_berr_const", 32'(brace_err), 32'd0);
    check_results("t5");

    // Idle timeout TIMEOUT cycles after the last transfer.
    start_capture();
    q = str2q("ab");
    send(q, 1'b0);
    repeat (TIMEOUT - 1) tick();
    check("t6_done_early",    32'(done),    32'd0);
    check("t6_timeout_early", 32'(timeout), 32'd0);
    tick();
    model_run(q);
    check_results("t6");
    start_capture();
    check("t6_restart_len",   32'(len),  32'd0);
    check("t6_restart_csum",  32'(csum), 32'd0);
    check("t6_restart_flags", 32'({brace_err, overflow, timeout}), 32'd0);
    check("t6_restart_done",  32'(done), 32'd0);
    check("t6_restart_busy",  32'(busy), 32'd1);
    q = {};
    q.push_back(8'h00);
    send(q, 1'b0);
    model_run(q);
    check_results("t6_empty");

    // Randomized streams, biased towards braces and occasional overflow.
    for (int t = 0; t < 20; t++) begin
      n_chars  = $urandom_range(0, 40);
      gap_mode = 1'($urandom_range(0, 1));
      q = {};
      for (int k = 0; k < n_chars; k++) begin
        r = $urandom_range(0, 9);
        if (r < 3)      c = 8'h7B;
        else if (r < 6) c = 8'h7D;
        else            c = 8'($urandom_range(1, 255));
        q.push_back(c);
      end
      q.push_back(8'h00);
      start_capture();
      send(q, gap_mode);
      model_run(q);
      check_results($sformatf("rnd%0d", t));
    end

    // Asynchronous reset in the middle of a stream.
    start_capture();
    send(str2q("ab{"), 1'b0);
    char_in    = 8'h63;
    char_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready",   32'(char_ready), 32'd0);
    check("arst_busy",    32'(busy),       32'd0);
    check("arst_done",    32'(done),       32'd0);
    check("arst_len",     32'(len),        32'd0);
    check("arst_csum",    32'(csum),       32'd0);
    check("arst_rd_data", 32'(rd_data),    32'd0);
    check("arst_flags",   32'({brace_err, overflow, timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_ready%0d", i), 32'(char_ready), 32'd0);
      check($sformatf("post_rst_len%0d", i),   32'(len),        32'd0);
    end
    char_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latex_stream_receiver.md
Name: latex_stream_receiver

Overview:
- Receiving end of the packed-ASCII LaTeX character stream that the transform engine drives out on lhs/rhs.
- Consumes one character per handshake and buffers one line up to a NUL terminator.
- Computes length, an XOR checksum and a brace-balance check, and exposes the buffer through a synchronous read port.
- Used on the bidirectional-IO input path for loopback self-test and for checking an external host's stream.

Parameters:
DEPTH, 32, character buffer entries (power of two, 4..64)
AW, 5, buffer address width = log2(DEPTH)
TIMEOUT, 255, idle cycles in CAPTURE before forced end (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge (registered compare) arms a new capture
char_in  in  8  ASCII character
char_valid  in  1  char_in valid this cycle
char_ready  out  1  receiver accepts char_in this cycle
rd_addr  in  AW  buffer read address
rd_data  out  8  buffer[rd_addr], one-cycle latency
busy  out  1  high in CAPTURE
done  out  1  high in DONE until next start edge
len  out  AW+1  characters stored (0..DEPTH), excludes terminator
csum  out  8  XOR of every accepted non-NUL character, including dropped ones
brace_err  out  1  '}' seen at depth 0, or depth != 0 at end
overflow  out  1  more than DEPTH non-NUL characters received
timeout  out  1  capture ended by idle timer

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - char_ready, busy, done, brace_err, overflow and timeout = 0.
  - len = 0, csum = 0x00, rd_data = 0x00.
  - Brace depth = 0, idle counter = 0, start_q = 0.
  - Buffer contents are not reset.
- States IDLE, CAPTURE, DONE.
  - IDLE/DONE -> CAPTURE on start & ~start_q. On that edge, clear len, csum, depth, all flags and the idle counter. CAPTURE is entered the next cycle.
  - CAPTURE -> DONE when a NUL is accepted, or when the idle counter reaches TIMEOUT (timeout=1).
  - A start edge during CAPTURE is ignored.
  - DONE holds all results until the next start edge.
- Handshake:
  - char_ready = 1 exactly in CAPTURE, registered, with no dependency on char_valid.
  - A transfer occurs on a cycle with char_valid & char_ready.
  - Characters presented outside CAPTURE are not consumed.
- Per accepted non-NUL character:
  - If len < DEPTH: write buffer[len] and increment len. Otherwise set overflow and drop the character.
  - csum ^= char always, including dropped characters.
  - '{' (0x7B): depth++, saturating at 15.
  - '}' (0x7D): if depth == 0, set brace_err; otherwise depth--.
  - Reset the idle counter.
- Accepted NUL:
  - Not stored.
  - brace_err |= (depth != 0).
  - Go to DONE. done rises the cycle after the NUL transfer.
- Idle counter:
  - Increments on every CAPTURE cycle without a transfer.
  - On timeout, brace_err |= (depth != 0).
- Flags are sticky within a capture.
  - Depth saturation does not itself set an error.
- Read port:
  - rd_data is registered as buffer[rd_addr] and is valid in any state.
  - Reading an address >= len returns stale contents.
  - A read and a write to the same address in the same cycle returns the old data.
- Reset asserted mid-capture: return to IDLE immediately. Results are lost.

Test Plan:
- Reset, start edge, stream "e^{at}" then NUL, valid every cycle -> char_ready=1 from the cycle after the start edge. done=1 one cycle after the NUL. len=6, csum=0x65^0x5E^0x7B^0x61^0x74^0x7D, brace_err=0, overflow=0, timeout=0. rd_addr 0..5 returns e,^,{,a,t,} with 1-cycle latency.
- Stream "\frac{1}{s-a}}" then NUL, with char_valid toggling every other cycle -> brace_err=1, len=14. No character is lost or duplicated across the gaps.
- Stream "{{s" then NUL -> brace_err=1 at end, len=3.
- Stream DEPTH+3 = 35 'x' characters then NUL -> len=32, overflow=1, csum=0x78 (odd count). Buffer holds 32 'x'.
- Start, send 2 characters, then hold char_valid low -> timeout=1 and done=1 exactly TIMEOUT idle cycles after the last transfer, len=2. A second start edge clears all flags and len.
- Deassert rst_n mid-stream -> outputs return to reset values asynchronously. After release with no start edge, char_ready stays 0 while char_valid=1.
